// File: rtl/register_file_pkg.sv
// Shared sizing constants for the 32 x 32-bit MIPS register file.
package register_file_pkg;
  localparam int DATA_W    = 32;
  localparam int ADDR_W    = 5;
  localparam int REG_COUNT = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] REG_ZERO = 5'd0;
endpackage

// File: rtl/register_file_if.sv
// Write/read bus of the register file: decode drives addresses and write data,
// the file returns two combinational read words.
interface register_file_if;
  import register_file_pkg::*;

  logic              write_en;
  logic [ADDR_W-1:0] write_addr;
  logic [DATA_W-1:0] write_data;
  logic [ADDR_W-1:0] read_addr_a;
  logic [ADDR_W-1:0] read_addr_b;
  logic [DATA_W-1:0] read_data_a;
  logic [DATA_W-1:0] read_data_b;

  modport master (
    output write_en, write_addr, write_data, read_addr_a, read_addr_b,
    input  read_data_a, read_data_b
  );

  modport slave (
    input  write_en, write_addr, write_data, read_addr_a, read_addr_b,
    output read_data_a, read_data_b
  );
endinterface

// File: rtl/register_file_decoder5_32.sv
// Write-side 5-to-32 one-hot decoder; all lines low when the enable is low.
module decoder5_32
  import register_file_pkg::*;
(
  input  logic                 en_i,
  input  logic [ADDR_W-1:0]    addr_i,
  output logic [REG_COUNT-1:0] onehot_o
);
  genvar gi;
  generate
    for (gi = 0; gi < REG_COUNT; gi++) begin : g_line
      assign onehot_o[gi] = en_i && (addr_i == ADDR_W'(gi));
    end
  endgenerate
endmodule

// File: rtl/register_file_mux32.sv
// Single-bit 32-to-1 selector; the read ports use one per data bit.
module mux32_1
  import register_file_pkg::*;
(
  input  logic [REG_COUNT-1:0] src_i,
  input  logic [ADDR_W-1:0]    sel_i,
  output logic                 bit_o
);
  assign bit_o = src_i[sel_i];
endmodule

// File: rtl/register_file.sv
// 31 writable registers (r0 reads as zero) with one write port and two
// combinational read ports; asynchronous active-low clear.
module register_file
  import register_file_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  register_file_if.slave  bus
);
  logic [REG_COUNT-1:0] we_lines;
  logic [DATA_W-1:0]    regs_q [1:REG_COUNT-1];
  logic [DATA_W-1:0]    regs_d [1:REG_COUNT-1];
  logic [REG_COUNT-1:0] bit_plane [DATA_W];
  logic [DATA_W-1:0]    rd_a;
  logic [DATA_W-1:0]    rd_b;
  logic                 unused_we_zero;

  decoder5_32 u_dec (
    .en_i     (bus.write_en),
    .addr_i   (bus.write_addr),
    .onehot_o (we_lines)
  );

  // r0 has no storage, so its enable line goes nowhere
  assign unused_we_zero = we_lines[REG_ZERO];

  always_comb begin
    for (int r = 1; r < REG_COUNT; r++) begin
      regs_d[r] = regs_q[r];
      if (we_lines[r]) regs_d[r] = bus.write_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 1; r < REG_COUNT; r++) regs_q[r] <= '0;
    end else begin
      for (int r = 1; r < REG_COUNT; r++) regs_q[r] <= regs_d[r];
    end
  end

  // Transpose storage into per-bit planes; plane bit 0 is the hardwired zero
  always_comb begin
    for (int b = 0; b < DATA_W; b++) begin
      bit_plane[b] = '0;
      for (int r = 1; r < REG_COUNT; r++) bit_plane[b][r] = regs_q[r][b];
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < DATA_W; gi++) begin : g_rd
      mux32_1 u_mux_a (
        .src_i (bit_plane[gi]),
        .sel_i (bus.read_addr_a),
        .bit_o (rd_a[gi])
      );
      mux32_1 u_mux_b (
        .src_i (bit_plane[gi]),
        .sel_i (bus.read_addr_b),
        .bit_o (rd_b[gi])
      );
    end
  endgenerate

  assign bus.read_data_a = rd_a;
  assign bus.read_data_b = rd_b;
endmodule

// File: tb/tb_register_file.sv
// Directed bench for register_file: a reference model feeds a scoreboard queue
// of expected read words that are popped and compared against the read ports.
module tb_register_file;
  logic clk;
  logic rst_n;
  register_file_if bus();

  register_file dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [31:0] exp;
    bit          port_b;
  } sb_item_t;

  sb_item_t    sb[$];
  logic [31:0] mdl [32];
  int          total = 0;
  int          bad   = 0;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic push_exp(input string tag, input logic [31:0] exp, input bit port_b);
    sb_item_t it;
    it.tag = tag; it.exp = exp; it.port_b = port_b;
    sb.push_back(it);
  endtask

  task automatic pop_check();
    sb_item_t    it;
    logic [31:0] obs;
    total++;
    if (sb.size() == 0) begin
      bad++;
      $error("FAIL scoreboard_empty observed=0 entries expected=1 entry");
    end else begin
      it  = sb.pop_front();
      obs = it.port_b ? bus.read_data_b : bus.read_data_a;
      assert (obs === it.exp) else begin
        bad++;
        $error("FAIL %s observed=%h expected=%h", it.tag, obs, it.exp);
      end
      $display("check %s port=%s observed=%h expected=%h", it.tag,
               it.port_b ? "B" : "A", obs, it.exp);
    end
  endtask

  // Present both read addresses, queue model values, compare after settling
  task automatic read_both(input string tag, input logic [4:0] aa, input logic [4:0] ab);
    bus.read_addr_a = aa;
    bus.read_addr_b = ab;
    push_exp(tag, mdl[aa], 1'b0);
    push_exp(tag, mdl[ab], 1'b1);
    #1;
    pop_check();
    pop_check();
  endtask

  task automatic do_write(input logic [4:0] a, input logic [31:0] d);
    @(negedge clk);
    bus.write_en   = 1'b1;
    bus.write_addr = a;
    bus.write_data = d;
    @(posedge clk);
    #1;
    bus.write_en = 1'b0;
    if (rst_n && a != 5'd0) mdl[a] = d;
  endtask

  task automatic clear_model();
    for (int i = 0; i < 32; i++) mdl[i] = 32'h0;
  endtask

  initial begin
    clear_model();
    rst_n = 1'b0;
    bus.write_en    = 1'b0;
    bus.write_addr  = 5'd0;
    bus.write_data  = 32'h0;
    bus.read_addr_a = 5'd0;
    bus.read_addr_b = 5'd0;
    #12;
    read_both("reset_state", 5'd5, 5'd31);
    @(negedge clk);
    rst_n = 1'b1;

    // Async reset clears r5 without a clock edge
    do_write(5'd5, 32'hDEADBEEF);
    read_both("r5_written", 5'd5, 5'd5);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    clear_model();
    #1;
    read_both("async_reset_r5", 5'd5, 5'd5);

    // Write attempted while reset held low is lost
    do_write(5'd6, 32'h0000_0001);
    @(negedge clk);
    rst_n = 1'b1;
    read_both("write_in_reset_dropped", 5'd6, 5'd6);

    // First edge after release accepts a write
    do_write(5'd8, 32'hCAFE_F00D);
    read_both("first_write_after_reset", 5'd8, 5'd0);

    for (int i = 1; i < 32; i++) do_write(5'(i), 32'h805C9BD2 ^ 32'(i));
    for (int i = 0; i < 32; i++) read_both($sformatf("all_regs_r%0d", i), 5'(i), 5'(i));

    // Writes to r0 are dropped and disturb nothing else
    do_write(5'd0, 32'hFFFF_FFFF);
    read_both("zero_reg", 5'd0, 5'd0);
    for (int i = 1; i < 32; i += 5) read_both($sformatf("after_r0_write_r%0d", i), 5'(i), 5'(31 - i));

    @(negedge clk);
    rst_n = 1'b0;
    clear_model();
    @(negedge clk);
    rst_n = 1'b1;

    // write_en low for three edges: r7 keeps its reset value
    @(negedge clk);
    bus.write_en   = 1'b0;
    bus.write_addr = 5'd7;
    bus.write_data = 32'h1234_5678;
    repeat (3) @(posedge clk);
    #1;
    read_both("write_en_low_r7", 5'd7, 5'd7);

    // No bypass: old value before the edge, new value after it
    do_write(5'd9, 32'h1111_1111);
    @(negedge clk);
    bus.write_en    = 1'b1;
    bus.write_addr  = 5'd9;
    bus.write_data  = 32'h2222_2222;
    bus.read_addr_a = 5'd9;
    push_exp("same_cycle_before_edge", mdl[9], 1'b0);
    #1;
    pop_check();
    @(posedge clk);
    #1;
    mdl[9] = 32'h2222_2222;
    bus.write_data = 32'h3333_3333;
    push_exp("same_cycle_after_edge", mdl[9], 1'b0);
    pop_check();
    @(posedge clk);
    #1;
    bus.write_en = 1'b0;
    mdl[9] = 32'h3333_3333;
    push_exp("back_to_back_last_wins", mdl[9], 1'b0);
    pop_check();

    do_write(5'd3, 32'hA5A5_A5A5);
    do_write(5'd4, 32'h5A5A_5A5A);
    read_both("dual_port_3_4", 5'd3, 5'd4);
    read_both("dual_port_4_4", 5'd4, 5'd4);
    read_both("dual_port_4_3", 5'd4, 5'd3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/register_file.md
# register_file

Architectural 32 x 32-bit general-purpose register file for the single-cycle MIPS datapath: the write side decodes a 5-bit register number into a one-hot enable and captures a word on the clock edge. The read side selects any register onto two combinational read ports. It sits between instruction decode (rs/rt/rd fields) and the ALU/writeback path. Register 0 is hardwired to zero.

## Interface

Parameters:
- DATA_W, 32, width of each register and of every data port.
- ADDR_W, 5, register-number width; register count is 2**ADDR_W = 32.

Ports:
- clk  input  1  rising-edge clock; one clock only.
- rst_n  input  1  asynchronous, active-low reset.
- write_en  input  1  write strobe, sampled on rising clk.
- write_addr  input  ADDR_W  destination register number (rd/rt).
- write_data  input  DATA_W  word to store.
- read_addr_a  input  ADDR_W  source register number for port A (rs).
- read_addr_b  input  ADDR_W  source register number for port B (rt).
- read_data_a  output  DATA_W  contents of register read_addr_a.
- read_data_b  output  DATA_W  contents of register read_addr_b.

## Operation

- Storage: 31 writable 32-bit registers, indices 1..31; index 0 has no storage.
- Write: on rising clk with rst_n high and write_en = 1, register[write_addr] <= write_data. All other registers hold.
- write_addr = 0 with write_en = 1: no state change; the write is silently dropped.
- write_en = 0: no register changes regardless of write_addr/write_data.
- Write decode: write_addr drives a 5-to-32 one-hot decoder gated by write_en. Exactly one enable line is high when write_en = 1; none are high otherwise. Enable line 0 is left unconnected.
- Read: read_data_x = register[read_addr_x], purely combinational. read_addr_x = 0 always returns 32'h0000_0000.
- Both read ports are independent; identical addresses on A and B return identical data.
- No internal write-to-read bypass. A read of the register being written returns the old value until the capturing edge, then the new value.
- Reset: asserting rst_n low clears registers 1..31 to 0 immediately, without waiting for clk. While rst_n is low, writes are ignored. Both read outputs show 0 for any address.
- Reset deassertion: the first write is accepted on the first rising clk at which rst_n is sampled high.

## Timing

- Write latency: 1 clock. Data is visible on the read ports after the rising edge at which write_en = 1, after combinational delay.
- Read latency: 0 clocks (combinational from read_addr_x and register state).
- Reset mid-operation: an asynchronous rst_n fall between edges clears all registers at once. A write pending on the next edge is lost if rst_n is still low at that edge.
- Simultaneous write and read of the same register in one cycle: read returns the pre-edge value for that cycle.
- Back-to-back writes to the same register on consecutive edges: the last write wins; each value is visible for exactly one cycle.
- Outputs after reset: read_data_a = read_data_b = 32'h0000_0000.

## Structure

- Shared defines header holds: DATA_W = 32, ADDR_W = 5, REG_COUNT = 32, REG_ZERO = 5'd0.
- Sub-module decoder5_32: 5-bit address plus enable in, 32-bit one-hot out. It is the write-side counterpart of the existing 32-to-1 bit selector.
- The read path reuses the existing 32-to-1 selector, bit-sliced: DATA_W instances per port. The source of each instance is bit i of all 32 registers.
- Register array: one always block sensitive to posedge clk / negedge rst_n.

## Test plan

- Reset: drive rst_n = 0 after writing 32'hDEADBEEF to r5. Without a clk edge, read_data_a for address 5 must be 32'h0 within the same timestep.
- Write/read all registers: write 32'h805C9BD2 ^ i to register i for i = 1..31. Read back on both ports. Each read must match. Address 0 must read 32'h0.
- Zero register: write_en = 1, write_addr = 0, write_data = 32'hFFFFFFFF. Reads of address 0 must stay 32'h0, and r1..r31 must be unchanged.
- write_en = 0: present write_addr = 7 and write_data = 32'h12345678 over 3 edges. r7 must keep its prior value (32'h0 after reset).
- Same-cycle read/write: with r9 = 32'h1111_1111, set write r9 <= 32'h2222_2222 and read_addr_a = 9. Port A must show 32'h11111111 before the edge and 32'h22222222 after it.
- Dual-port independence: r3 = 32'hA5A5A5A5 and r4 = 32'h5A5A5A5A. Read A = 3 and B = 4, then A = B = 4. The outputs must match the register contents with no cross-coupling.
